// File: rtl/xotr_phase_sequencer_if.sv
// ============================================================================
// Module  : xotr_phase_sequencer_if
// Brief   : Single-outstanding memory request/acknowledge bus between the
//           XOTR phase sequencer (master) and the bus interface unit (slave).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface xotr_phase_sequencer_if;
    logic       mem_rd_req;
    logic       mem_wr_req;
    logic [1:0] mem_slot;
    logic       mem_ack;

    modport master (
        output mem_rd_req,
        output mem_wr_req,
        output mem_slot,
        input  mem_ack
    );

    modport slave (
        input  mem_rd_req,
        input  mem_wr_req,
        input  mem_slot,
        output mem_ack
    );
endinterface

`default_nettype wire

// File: rtl/xotr_phase_sequencer.sv
// ============================================================================
// Module  : xotr_phase_sequencer
// Brief   : Phase sequencer for ED-prefixed (XOTR) opcodes. Owns XPT/notXPT,
//           XOTR and CM1, and turns decoder R/W strobes into a req/ack cycle.
//           Optional bus watchdog: define XOTR_BUS_TIMEOUT_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module xotr_phase_sequencer #(
    parameter int MAX_XPT = 31,
    parameter int TIMEOUT = 15
) (
    input  wire logic       clock,
    input  wire logic       notReset,
    input  wire logic       start,
    input  wire logic       PR_Reset_XPT,
    input  wire logic       P2_Set_CM1,
    input  wire logic       P2_Reset_XOTR,
    input  wire logic [2:0] PC_R,
    input  wire logic [2:0] PC_W,
    xotr_phase_sequencer_if.master bus,
    output logic      [4:0] XPT,
    output logic      [4:0] notXPT,
    output logic            XOTR,
    output logic            CM1,
    output logic            busy,
    output logic            err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EXEC  = 2'd1,
        ST_READ  = 2'd2,
        ST_WRITE = 2'd3
    } state_t;

    localparam logic [4:0] c_max_xpt   = 5'(MAX_XPT);
    localparam logic [3:0] c_wait_last = 4'(TIMEOUT - 1);

    // The wait counter is 4 bits wide, so TIMEOUT must fit in 1..16.
    if (TIMEOUT < 1 || TIMEOUT > 16 || c_wait_last > 4'd15) begin : g_bad_timeout
        $error("TIMEOUT out of range");
    end
    if (MAX_XPT < 1 || MAX_XPT > 31) begin : g_bad_max_xpt
        $error("MAX_XPT out of range");
    end

    state_t     state_q,  state_d;
    logic [4:0] xpt_q,    xpt_d;
    logic [4:0] notxpt_q, notxpt_d;
    logic       xotr_q,   xotr_d;
    logic       cm1_q,    cm1_d;
    logic       rd_q,     rd_d;
    logic       wr_q,     wr_d;
    logic [1:0] slot_q,   slot_d;
    logic       busy_q,   busy_d;
    logic       err_q,    err_d;
`ifdef XOTR_BUS_TIMEOUT_EN
    logic [3:0] wait_q,   wait_d;
`endif
    logic       fault;
    logic       r_multi;
    logic       w_multi;
    logic [1:0] strobe_idx;

    assign r_multi    = (PC_R & (PC_R - 3'd1)) != 3'd0;
    assign w_multi    = (PC_W & (PC_W - 3'd1)) != 3'd0;
    assign strobe_idx = ((PC_R[1] | PC_W[1]) ? 2'd1 : 2'd0)
                      | ((PC_R[2] | PC_W[2]) ? 2'd2 : 2'd0);

    always_comb begin
        state_d = state_q;
        xpt_d   = xpt_q;
        xotr_d  = xotr_q;
        cm1_d   = cm1_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        slot_d  = slot_q;
        err_d   = err_q;
        fault   = 1'b0;
`ifdef XOTR_BUS_TIMEOUT_EN
        wait_d  = wait_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_EXEC;
                    xpt_d   = 5'd0;
                    xotr_d  = 1'b1;
                    cm1_d   = 1'b0;
                end
            end
            ST_EXEC: begin
                if (PR_Reset_XPT) begin
                    state_d = ST_IDLE;
                    xpt_d   = 5'd0;
                    if (P2_Reset_XOTR) xotr_d = 1'b0;
                    if (P2_Set_CM1)    cm1_d  = 1'b1;
                end else if (r_multi || w_multi || (PC_R != 3'd0 && PC_W != 3'd0)) begin
                    fault = 1'b1;
                end else if (PC_R != 3'd0 || PC_W != 3'd0) begin
                    state_d = (PC_R != 3'd0) ? ST_READ : ST_WRITE;
                    rd_d    = (PC_R != 3'd0);
                    wr_d    = (PC_W != 3'd0);
                    slot_d  = strobe_idx;
`ifdef XOTR_BUS_TIMEOUT_EN
                    wait_d  = 4'd0;
`endif
                end else if (xpt_q == c_max_xpt) begin
                    fault = 1'b1;
                end else begin
                    xpt_d = xpt_q + 5'd1;
                end
            end
            default: begin
                // Bus cycle in flight: XPT frozen, decoder strobes ignored.
                if (bus.mem_ack) begin
                    state_d = ST_EXEC;
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    xpt_d   = xpt_q + 5'd1;
`ifdef XOTR_BUS_TIMEOUT_EN
                end else if (wait_q == c_wait_last) begin
                    fault  = 1'b1;
                end else begin
                    wait_d = wait_q + 4'd1;
`endif
                end
            end
        endcase

        if (fault) begin
            state_d = ST_IDLE;
            err_d   = 1'b1;
            xpt_d   = 5'd0;
            xotr_d  = 1'b0;
            cm1_d   = 1'b1;
            rd_d    = 1'b0;
            wr_d    = 1'b0;
        end

        notxpt_d = ~xpt_d;
        busy_d   = (state_d != ST_IDLE);
    end

    always_ff @(posedge clock) begin
        if (!notReset) begin
            state_q  <= ST_IDLE;
            xpt_q    <= 5'd0;
            notxpt_q <= 5'h1F;
            xotr_q   <= 1'b0;
            cm1_q    <= 1'b1;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            slot_q   <= 2'd0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
`ifdef XOTR_BUS_TIMEOUT_EN
            wait_q   <= 4'd0;
`endif
        end else begin
            state_q  <= state_d;
            xpt_q    <= xpt_d;
            notxpt_q <= notxpt_d;
            xotr_q   <= xotr_d;
            cm1_q    <= cm1_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            slot_q   <= slot_d;
            busy_q   <= busy_d;
            err_q    <= err_d;
`ifdef XOTR_BUS_TIMEOUT_EN
            wait_q   <= wait_d;
`endif
        end
    end

    assign XPT            = xpt_q;
    assign notXPT         = notxpt_q;
    assign XOTR           = xotr_q;
    assign CM1            = cm1_q;
    assign busy           = busy_q;
    assign err            = err_q;
    assign bus.mem_rd_req = rd_q;
    assign bus.mem_wr_req = wr_q;
    assign bus.mem_slot   = slot_q;

endmodule

`default_nettype wire

// File: tb/tb_xotr_phase_sequencer.sv
// ============================================================================
// Module  : tb_xotr_phase_sequencer
// Brief   : Directed plus randomized bench for xotr_phase_sequencer against a
//           cycle-level behavioural model of the XOTR sequencing rules.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_xotr_phase_sequencer;

    logic       clock = 1'b0;
    logic       notReset;
    logic       start, pr, p2s, p2r;
    logic [2:0] pc_r, pc_w;
    logic [4:0] XPT, notXPT;
    logic       XOTR, CM1, busy, err;

    int errors = 0;
    int checks = 0;
    bit cmp_en = 1'b0;
    int rd_starts = 0;
    int wr_starts = 0;
    logic rd_prev = 1'b0;
    logic wr_prev = 1'b0;

    xotr_phase_sequencer_if bus_if ();

    xotr_phase_sequencer #(
        .MAX_XPT (31),
        .TIMEOUT (15)
    ) dut (
        .clock         (clock),
        .notReset      (notReset),
        .start         (start),
        .PR_Reset_XPT  (pr),
        .P2_Set_CM1    (p2s),
        .P2_Reset_XOTR (p2r),
        .PC_R          (pc_r),
        .PC_W          (pc_w),
        .bus           (bus_if),
        .XPT           (XPT),
        .notXPT        (notXPT),
        .XOTR          (XOTR),
        .CM1           (CM1),
        .busy          (busy),
        .err           (err)
    );

    always #5 clock = ~clock;

    // Behavioural model: an instruction is either not running, running, or
    // running with one bus transfer pending (1 = read, 2 = write).
    bit m_run, m_xotr, m_cm1, m_err;
    int m_pend, m_xpt, m_slot, m_wait;
`ifdef XOTR_BUS_TIMEOUT_EN
    localparam int TIMEOUT = 15;
`endif

    task automatic m_fault();
        m_err = 1; m_run = 0; m_pend = 0; m_xpt = 0; m_xotr = 0; m_cm1 = 1;
    endtask

    always @(posedge clock) begin
        if (!notReset) begin
            m_run = 0; m_pend = 0; m_xpt = 0; m_xotr = 0; m_cm1 = 1; m_slot = 0; m_err = 0;
        end else if (!m_run) begin
            if (start) begin m_run = 1; m_xpt = 0; m_xotr = 1; m_cm1 = 0; end
        end else if (m_pend != 0) begin
            if (bus_if.mem_ack) begin
                m_pend = 0;
                m_xpt  = (m_xpt + 1) % 32;
            end
`ifdef XOTR_BUS_TIMEOUT_EN
            else begin
                m_wait++;
                if (m_wait == TIMEOUT) m_fault();
            end
`endif
        end else if (pr) begin
            m_run = 0; m_xpt = 0;
            if (p2r) m_xotr = 0;
            if (p2s) m_cm1 = 1;
        end else if ($countones(pc_r) > 1 || $countones(pc_w) > 1 || (pc_r != 0 && pc_w != 0)) begin
            m_fault();
        end else if (pc_r != 0) begin
            m_pend = 1; m_slot = $clog2(pc_r); m_wait = 0;
        end else if (pc_w != 0) begin
            m_pend = 2; m_slot = $clog2(pc_w); m_wait = 0;
        end else if (m_xpt == 31) begin
            m_fault();
        end else begin
            m_xpt++;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Per-cycle comparison against the model, sampled mid-cycle.
    always @(negedge clock) begin
        if (cmp_en) begin
            logic [4:0] ex, enx;
            logic       erd, ewr;
            ex  = m_xpt[4:0];
            enx = ~ex;
            erd = (m_pend == 1);
            ewr = (m_pend == 2);
            chk("XPT", XPT, ex);
            chk("notXPT", notXPT, enx);
            chk("XOTR", XOTR, m_xotr);
            chk("CM1", CM1, m_cm1);
            chk("busy", busy, m_run);
            chk("err", err, m_err);
            chk("mem_rd_req", bus_if.mem_rd_req, erd);
            chk("mem_wr_req", bus_if.mem_wr_req, ewr);
            if (m_pend != 0) chk("mem_slot", bus_if.mem_slot, m_slot);
        end
        if (bus_if.mem_rd_req === 1'b1 && rd_prev !== 1'b1) rd_starts++;
        if (bus_if.mem_wr_req === 1'b1 && wr_prev !== 1'b1) wr_starts++;
        rd_prev = bus_if.mem_rd_req;
        wr_prev = bus_if.mem_wr_req;
    end

    task automatic tick();
        @(negedge clock);
        #2;
    endtask

    task automatic idle_in();
        start = 0; pr = 0; p2s = 0; p2r = 0; pc_r = 0; pc_w = 0; bus_if.mem_ack = 0;
    endtask

    task automatic do_reset();
        idle_in();
        notReset = 0;
        tick();
        notReset = 1;
    endtask

    task automatic run_to(input int n);
        int g = 0;
        while (XPT !== 5'(n) && g < 40) begin
            tick();
            g++;
        end
        chk("run_to_xpt", XPT, n);
    endtask

    task automatic begin_instr();
        start = 1;
        tick();
        start = 0;
    endtask

    task automatic end_instr();
        pr = 1; p2s = 1; p2r = 1;
        tick();
        idle_in();
    endtask

    initial begin
        int bcnt, rcnt, r0, w0;
        idle_in();
        notReset = 0;
        tick();
        cmp_en = 1;
        tick();
        notReset = 1;
        chk("rst_XPT", XPT, 0);
        chk("rst_notXPT", notXPT, 5'h1F);
        chk("rst_CM1", CM1, 1);
        chk("rst_XOTR", XOTR, 0);
        chk("rst_busy", busy, 0);
        chk("rst_req", {bus_if.mem_rd_req, bus_if.mem_wr_req}, 0);
        tick();

        // IM-style: no memory, finish at XPT=3.
        begin_instr();
        bcnt = 0;
        for (int i = 0; i < 4; i++) begin
            chk("im_xpt", XPT, i);
            bcnt += int'(busy);
            if (i == 3) begin pr = 1; p2s = 1; p2r = 1; end
            tick();
        end
        idle_in();
        chk("im_busy_cycles", bcnt, 4);
        chk("im_busy_end", busy, 0);
        chk("im_xotr_end", XOTR, 0);
        chk("im_cm1_end", CM1, 1);
        tick();

        // Single read at XPT=2 with three wait cycles.
        begin_instr();
        run_to(2);
        pc_r = 3'b001;
        tick();
        pc_r = 0;
        rcnt = 0;
        for (int j = 0; j < 3; j++) begin
            chk("rd_xpt_held", XPT, 2);
            chk("rd_slot", bus_if.mem_slot, 0);
            rcnt += int'(bus_if.mem_rd_req);
            if (j == 2) bus_if.mem_ack = 1;
            tick();
        end
        bus_if.mem_ack = 0;
        chk("rd_high_cycles", rcnt, 3);
        chk("rd_dropped", bus_if.mem_rd_req, 0);
        chk("rd_xpt_after", XPT, 3);
        end_instr();

        // RRD-style: read at 2, write at 6, finish at 8.
        r0 = rd_starts; w0 = wr_starts;
        begin_instr();
        run_to(2);
        pc_r = 3'b001; tick(); pc_r = 0;
        bus_if.mem_ack = 1; tick(); bus_if.mem_ack = 0;
        run_to(6);
        pc_w = 3'b001; tick(); pc_w = 0;
        chk("rrd_wr_slot", bus_if.mem_slot, 0);
        bus_if.mem_ack = 1; tick(); bus_if.mem_ack = 0;
        run_to(8);
        end_instr();
        chk("rrd_reads", rd_starts - r0, 1);
        chk("rrd_writes", wr_starts - w0, 1);
        chk("rrd_xotr", XOTR, 0);

        // Illegal strobes: multi-hot read, then read+write together.
        r0 = rd_starts; w0 = wr_starts;
        begin_instr();
        pc_r = 3'b011; tick(); pc_r = 0;
        chk("multi_err", err, 1);
        chk("multi_busy", busy, 0);
        do_reset();
        chk("err_cleared", err, 0);
        begin_instr();
        pc_r = 3'b001; pc_w = 3'b010; tick(); idle_in();
        chk("rw_err", err, 1);
        chk("rw_xpt", XPT, 0);
        chk("illegal_no_req", (rd_starts - r0) + (wr_starts - w0), 0);
        do_reset();

        // Run off the end of the phase counter.
        begin_instr();
        run_to(31);
        chk("max_err_before", err, 0);
        tick();
        chk("max_err", err, 1);
        chk("max_xpt", XPT, 0);
        chk("max_cm1", CM1, 1);
        do_reset();

`ifdef XOTR_BUS_TIMEOUT_EN
        begin_instr();
        pc_r = 3'b100; tick(); pc_r = 0;
        rcnt = 0;
        for (int j = 0; j < 20; j++) begin
            rcnt += int'(bus_if.mem_rd_req);
            tick();
        end
        chk("to_req_cycles", rcnt, 15);
        chk("to_err", err, 1);
        do_reset();
        begin_instr();
        pc_r = 3'b100; tick(); pc_r = 0;
        for (int j = 0; j < 15; j++) begin
            if (j == 14) bus_if.mem_ack = 1;
            tick();
        end
        bus_if.mem_ack = 0;
        chk("to_ack_wins_err", err, 0);
        chk("to_ack_wins_xpt", XPT, 1);
        end_instr();
`else
        begin_instr();
        pc_r = 3'b100; tick(); pc_r = 0;
        repeat (20) tick();
        chk("nowd_req_held", bus_if.mem_rd_req, 1);
        chk("nowd_err", err, 0);
        bus_if.mem_ack = 1; tick(); bus_if.mem_ack = 0;
        chk("nowd_xpt", XPT, 1);
        end_instr();
`endif

        // Randomized traffic, the model checks every cycle.
        for (int k = 0; k < 3000; k++) begin
            int sel;
            notReset       = ($urandom_range(0, 149) != 0);
            start          = ($urandom_range(0, 5) == 0);
            pr             = ($urandom_range(0, 9) == 0);
            p2s            = 1'($urandom_range(0, 1));
            p2r            = 1'($urandom_range(0, 1));
            bus_if.mem_ack = ($urandom_range(0, 2) == 0);
            sel  = $urandom_range(0, 19);
            pc_r = 0; pc_w = 0;
            case (sel)
                0: pc_r = 3'(1 << $urandom_range(0, 2));
                1: pc_w = 3'(1 << $urandom_range(0, 2));
                2: pc_r = 3'($urandom_range(0, 7));
                3: begin pc_r = 3'($urandom_range(0, 7)); pc_w = 3'($urandom_range(0, 7)); end
                default: ;
            endcase
            tick();
        end
        idle_in();
        notReset = 1;
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire

// File: doc/xotr_phase_sequencer.md
Name: xotr_phase_sequencer

Overview:
- Sequences execution phases of extended (ED-prefixed, XOTR) opcodes, e.g. IM n, LD A,I/R, LD I/R,A, RRD/RLD.
- Owns the 5-bit phase counter XPT/notXPT that feeds the XOTR decoder tree, plus the XOTR and CM1 flags.
- Converts decoder memory-cycle strobes (PC_R0..2, PC_W0..2) into a single-outstanding req/ack bus handshake, stalling XPT until the bus completes.
- Sits between the XOTR decoder and the bus interface unit.

Parameters:
- MAX_XPT, 31: highest legal XPT value; reaching it without PR_Reset_XPT is a sequencing fault.
- TIMEOUT, 15: cycles a bus request may wait for mem_ack (used only with the optional feature).

Ports:
- clock  in  1  system clock, rising edge
- notReset  in  1  synchronous active-low reset
- start  in  1  pulse: ED prefix fetched, begin XOTR execution
- PR_Reset_XPT  in  1  decoder: instruction finished, clear XPT
- P2_Set_CM1  in  1  decoder: next cycle is opcode fetch (M1)
- P2_Reset_XOTR  in  1  decoder: leave XOTR mode
- PC_R  in  3  decoder read-cycle strobes R0..R2, one-hot or zero
- PC_W  in  3  decoder write-cycle strobes W0..W2, one-hot or zero
- mem_ack  in  1  bus unit: current cycle complete (1-cycle pulse)
- XPT  out  5  phase counter to decoder
- notXPT  out  5  bitwise complement of XPT, always consistent
- XOTR  out  1  extended-op execution flag
- CM1  out  1  request M1 fetch
- mem_rd_req  out  1  read request, level, held until ack
- mem_wr_req  out  1  write request, level, held until ack
- mem_slot  out  2  index 0..2 of the active R/W strobe
- busy  out  1  high whenever state != IDLE
- err  out  1  sticky fault flag

Behaviour:
- All state changes on the rising clock edge.
- notReset=0 (synchronous) forces state IDLE, XPT=0, notXPT=5'h1F, XOTR=0, CM1=1, mem_rd_req=0, mem_wr_req=0, mem_slot=0, err=0.
- Reset mid-bus-cycle drops the request immediately; a late mem_ack is ignored.
- States: IDLE, EXEC, READ, WRITE.
- IDLE:
  - start=1 -> EXEC; XOTR=1, CM1=0, XPT=0.
  - All other inputs are ignored.
- EXEC, evaluated in this priority order:
  1. PR_Reset_XPT=1 -> IDLE; XPT=0. XOTR is cleared iff P2_Reset_XOTR=1. CM1 is set iff P2_Set_CM1=1.
  2. PC_R and PC_W both nonzero, or either is multi-hot -> err=1, IDLE, XPT=0, XOTR=0, CM1=1.
  3. PC_R nonzero -> READ; mem_rd_req=1 from the next cycle; mem_slot = index of the set bit.
  4. PC_W nonzero -> WRITE; mem_wr_req=1; mem_slot as above.
  5. Otherwise XPT<=XPT+1.
     - If XPT==MAX_XPT, do not wrap: err=1, IDLE, XPT=0, XOTR=0, CM1=1.
- READ / WRITE:
  - XPT is frozen; decoder strobes are ignored, including PR_Reset_XPT.
  - On mem_ack=1: drop the request, XPT<=XPT+1, return to EXEC.
  - Exactly one bus cycle per XPT value; a strobe still asserted after the increment is a new request at the new XPT.
- Latency:
  - strobe seen in EXEC -> request asserted 1 cycle later.
  - ack -> next XPT value 1 cycle later.
- Minimum instruction (no memory): start, then N+1 EXEC cycles, where N is the XPT value at which PR_Reset_XPT asserts.
- start while busy is ignored.
- err clears only on reset.

Optional Feature:
- Macro: XOTR_BUS_TIMEOUT_EN.
- Enabled:
  - 4-bit wait counter, cleared on entry to READ/WRITE, incremented each cycle without ack.
  - Reaching TIMEOUT drops the request, sets err=1, and goes to IDLE with XPT=0, XOTR=0, CM1=1.
  - An ack arriving in the same cycle as the timeout wins.
- Disabled: no counter; READ/WRITE waits indefinitely.

Test Plan:
- Reset held 2 cycles, then released -> XPT=0, notXPT=5'h1F, CM1=1, XOTR=0, busy=0, no requests.
- start; PR_Reset_XPT+P2_Set_CM1+P2_Reset_XOTR at XPT=3 (IM-style) -> XPT steps 0,1,2,3, then XPT=0, XOTR=0, CM1=1, IDLE; busy high for exactly 4 cycles.
- start; PC_R=3'b001 at XPT=2; mem_ack after 3 wait cycles -> mem_rd_req high 3 cycles with mem_slot=0 and XPT held at 2; then XPT=3.
- RRD-style sequence: PC_R0 at XPT=2, PC_W0 at XPT=6, each acked after 1 cycle, reset at XPT=8 -> exactly one read and one write, slots 0/0, final XOTR=0.
- PC_R=3'b011, or PC_R and PC_W both nonzero in EXEC -> err=1 next cycle, IDLE, no request ever raised; start without a valid sequence, counting to MAX_XPT=31 -> err=1 with XPT=0.
- With XOTR_BUS_TIMEOUT_EN and TIMEOUT=15: read request never acked -> request drops after 15 cycles, err=1; ack arriving on cycle 15 -> normal completion, err=0.
